// File: rtl/hoop_collision_detector_pkg.sv
// Shared types and defaults for the hoop collision detector.
package hoop_coll_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    CAUGHT = 2'd1,
    MISSED = 2'd2
  } pass_state_t;

  localparam int Y_W          = 11;
  localparam int SCREEN_H_DEF = 480;

endpackage

// File: rtl/hoop_collision_detector_if.sv
// Frame/draw-request inputs and collision/score outputs of the hoop collision detector.
interface hoop_collision_detector_if;
  import hoop_coll_pkg::*;

  logic                  startOfFrame;
  logic                  pause;
  logic                  hoopDR;
  logic                  towerDR;
  logic                  playerDR;
  logic signed [Y_W-1:0] hoopTopLeftY;
  logic                  towerHoopCollision;
  logic                  hoopCaught;
  logic                  hoopMissed;
  logic [15:0]           catchCount;
  logic [15:0]           missCount;

  modport master (
    output startOfFrame, pause, hoopDR, towerDR, playerDR, hoopTopLeftY,
    input  towerHoopCollision, hoopCaught, hoopMissed, catchCount, missCount
  );

  modport slave (
    input  startOfFrame, pause, hoopDR, towerDR, playerDR, hoopTopLeftY,
    output towerHoopCollision, hoopCaught, hoopMissed, catchCount, missCount
  );

endinterface

// File: rtl/hoop_collision_detector_overlap_counter.sv
// Saturating per-frame overlap counter; flag is either registered (qualify) or a live threshold.
module overlap_counter #(
  parameter int CNT_W    = 12,
  parameter int MIN_PIX  = 4,
  parameter bit REG_FLAG = 1'b1
) (
  input  logic clk,
  input  logic resetN,
  input  logic sof,
  input  logic pause,
  input  logic hit,
  output logic flag
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_PIX);

  logic [CNT_W-1:0] count_reg, count_next;

  // The SOF-cycle pixel already belongs to the new frame.
  always_comb begin
    count_next = count_reg;
    if (pause)
      count_next = '0;
    else if (sof)
      count_next = hit ? CNT_W'(1) : '0;
    else if (hit && (count_reg != CNT_MAX))
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  generate
    if (REG_FLAG) begin : g_reg
      logic flag_reg;
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
          flag_reg <= 1'b0;
        else
          flag_reg <= !pause && !sof && (count_reg >= MIN_VAL);
      end
      assign flag = flag_reg;
    end else begin : g_comb
      assign flag = (count_reg >= MIN_VAL);
    end
  endgenerate

endmodule

// File: rtl/hoop_collision_detector.sv
// Frame-accurate hoop/tower collision flag and per-pass catch/miss pulses.
// Optional HOOP_COLL_STATS_EN adds 16-bit catch/miss totals.
module hoop_collision_detector
  import hoop_coll_pkg::*;
#(
  parameter int TOWER_MIN_PIX = 4,
  parameter int CATCH_MIN_PIX = 16,
  parameter int CNT_W         = 12,
  parameter int SCREEN_H      = SCREEN_H_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  hoop_collision_detector_if.slave bus
);

  localparam logic signed [Y_W-1:0] SCREEN_Y = Y_W'(SCREEN_H);

  logic                  tower_flag;
  logic                  catch_ok;
  pass_state_t           state_reg, state_next;
  logic signed [Y_W-1:0] prev_y_reg;
  logic                  caught_reg, caught_next;
  logic                  missed_reg, missed_next;

  overlap_counter #(.CNT_W(CNT_W), .MIN_PIX(TOWER_MIN_PIX), .REG_FLAG(1'b1)) u_tower (
    .clk    (clk),
    .resetN (resetN),
    .sof    (bus.startOfFrame),
    .pause  (bus.pause),
    .hit    (bus.hoopDR & bus.towerDR),
    .flag   (tower_flag)
  );

  // Live threshold so the SOF cycle sees the completed frame's count.
  overlap_counter #(.CNT_W(CNT_W), .MIN_PIX(CATCH_MIN_PIX), .REG_FLAG(1'b0)) u_player (
    .clk    (clk),
    .resetN (resetN),
    .sof    (bus.startOfFrame),
    .pause  (bus.pause),
    .hit    (bus.hoopDR & bus.playerDR),
    .flag   (catch_ok)
  );

  always_comb begin
    state_next  = state_reg;
    caught_next = 1'b0;
    missed_next = 1'b0;
    if (bus.startOfFrame && !bus.pause) begin
      case (state_reg)
        ARMED: begin
          if (catch_ok) begin
            caught_next = 1'b1;
            state_next  = CAUGHT;
          end else if (bus.hoopTopLeftY > SCREEN_Y) begin
            missed_next = 1'b1;
            state_next  = MISSED;
          end
        end
        CAUGHT, MISSED: begin
          if (bus.hoopTopLeftY < prev_y_reg)
            state_next = ARMED;
        end
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= ARMED;
      prev_y_reg <= '0;
      caught_reg <= 1'b0;
      missed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      caught_reg <= caught_next;
      missed_reg <= missed_next;
      if (bus.startOfFrame)
        prev_y_reg <= bus.hoopTopLeftY;
    end
  end

  assign bus.towerHoopCollision = tower_flag;
  assign bus.hoopCaught         = caught_reg;
  assign bus.hoopMissed         = missed_reg;

`ifdef HOOP_COLL_STATS_EN
  logic [15:0] catch_cnt_reg, miss_cnt_reg;

  // Counted on the same edge the pulse is raised; wraps naturally.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      catch_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
    end else begin
      if (caught_next) catch_cnt_reg <= catch_cnt_reg + 16'd1;
      if (missed_next) miss_cnt_reg  <= miss_cnt_reg + 16'd1;
    end
  end

  assign bus.catchCount = catch_cnt_reg;
  assign bus.missCount  = miss_cnt_reg;
`else
  assign bus.catchCount = 16'd0;
  assign bus.missCount  = 16'd0;
`endif

endmodule

// File: tb/tb_hoop_collision_detector.sv
// Directed bench: pulse scoreboard plus point checks of the tower flag and stats counters.
module tb_hoop_collision_detector;

  typedef struct {
    int e;
    bit is_catch;
  } ev_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_cnt    = 0;
  int   exp_catch   = 0;
  int   exp_miss    = 0;
  int   cur_y       = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  hoop_collision_detector_if bus();

  hoop_collision_detector dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick(input bit s, input bit pz, input bit h, input bit t, input bit p, input int y);
    bus.startOfFrame = s;
    bus.pause        = pz;
    bus.hoopDR       = h;
    bus.towerDR      = t;
    bus.playerDR     = p;
    bus.hoopTopLeftY = 11'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int n, input bit t, input bit p);
    repeat (n) tick(1'b0, 1'b0, 1'b1, t, p, cur_y);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cur_y);
  endtask

  // ev: 0 none, 1 catch expected, 2 miss expected
  task automatic sof(input int y, input int ev);
    ev_t item;
    cur_y = y;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, y);
    if (ev != 0) begin
      item.e        = edge_cnt;
      item.is_catch = (ev == 1);
      exp_q.push_back(item);
      if (ev == 1) exp_catch++;
      else         exp_miss++;
    end
    $display("sof y=%0d expect %s", y, ev == 1 ? "catch" : ev == 2 ? "miss" : "none");
  endtask

  task automatic check_stats(input string tag);
`ifdef HOOP_COLL_STATS_EN
    check({tag, " catchCount"}, 32'(bus.catchCount), 32'(exp_catch));
    check({tag, " missCount"},  32'(bus.missCount),  32'(exp_miss));
`else
    check({tag, " catchCount"}, 32'(bus.catchCount), 32'd0);
    check({tag, " missCount"},  32'(bus.missCount),  32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (resetN && (bus.hoopCaught || bus.hoopMissed)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pulse: got caught=%0b missed=%0b at edge %0d, required none",
                 bus.hoopCaught, bus.hoopMissed, edge_cnt);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        if (ev.e != edge_cnt || ev.is_catch != bus.hoopCaught || bus.hoopCaught == bus.hoopMissed) begin
          miscompares++;
          $display("FAIL pulse: got caught=%0b missed=%0b at edge %0d, required %s at edge %0d",
                   bus.hoopCaught, bus.hoopMissed, edge_cnt, ev.is_catch ? "caught" : "missed", ev.e);
        end else begin
          $display("ok   pulse %s at edge %0d", ev.is_catch ? "caught" : "missed", edge_cnt);
        end
      end
    end
  end

  initial begin
    bus.startOfFrame = 1'b0;
    bus.pause        = 1'b0;
    bus.hoopDR       = 1'b0;
    bus.towerDR      = 1'b0;
    bus.playerDR     = 1'b0;
    bus.hoopTopLeftY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset tower", 32'(bus.towerHoopCollision), 32'd0);
    check("reset caught", 32'(bus.hoopCaught), 32'd0);
    check("reset missed", 32'(bus.hoopMissed), 32'd0);
    check_stats("reset");
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;

    // Tower overlap qualification
    sof(100, 0);
    pix(4, 1'b1, 1'b0);
    check("tower after 4 edges", 32'(bus.towerHoopCollision), 32'd0);
    idle(1);
    check("tower 5th edge", 32'(bus.towerHoopCollision), 32'd1);
    idle(3);
    check("tower in SOF cycle", 32'(bus.towerHoopCollision), 32'd1);
    sof(100, 0);
    check("tower cleared at SOF", 32'(bus.towerHoopCollision), 32'd0);
    pix(3, 1'b1, 1'b0);
    idle(3);
    check("tower 3 pixels", 32'(bus.towerHoopCollision), 32'd0);

    // Catch, no repeat within pass, respawn
    pix(16, 1'b0, 1'b1);
    sof(200, 1);
    pix(20, 1'b0, 1'b1);
    sof(250, 0);
    sof(481, 0);
    sof(-58, 0);

    // Miss, no second pulse, respawn, negative Y is not an exit
    sof(481, 2);
    sof(490, 0);
    sof(-60, 0);
    sof(-30, 0);

    // Catch and exit on the same SOF
    pix(20, 1'b0, 1'b1);
    sof(485, 1);
    sof(490, 0);
    sof(-50, 0);

    // Pause mid-frame
    pix(10, 1'b1, 1'b1);
    check("tower before pause", 32'(bus.towerHoopCollision), 32'd1);
    repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, cur_y);
    check("tower while paused", 32'(bus.towerHoopCollision), 32'd0);
    pix(10, 1'b0, 1'b1);
    sof(100, 0);
    check("tower after pause frame", 32'(bus.towerHoopCollision), 32'd0);

    // Stats totals
    pix(16, 1'b0, 1'b1);
    sof(200, 1);
    sof(-10, 0);
    sof(481, 2);
    idle(2);
    check_stats("totals");

    // Reset mid-frame
    sof(-20, 0);
    pix(5, 1'b1, 1'b0);
    check("tower before reset", 32'(bus.towerHoopCollision), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("midreset tower", 32'(bus.towerHoopCollision), 32'd0);
    check("midreset caught", 32'(bus.hoopCaught), 32'd0);
    check("midreset missed", 32'(bus.hoopMissed), 32'd0);
    exp_catch = 0;
    exp_miss  = 0;
    check_stats("midreset");
    @(posedge clk);
    #3 resetN = 1'b1;
    @(posedge clk);
    #1;
    sof(481, 2);
    idle(2);
    check_stats("after reset");

    idle(3);
    while (exp_q.size() > 0) begin
      ev_t ev;
      ev = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL pulse: got none, required %s at edge %0d", ev.is_catch ? "caught" : "missed", ev.e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
